// File: rtl/soc_design_fb_pkg.sv
// Shared definitions for the framebuffer reader: FSM states, Avalon widths and
// the bytes-per-word helper used for address alignment and burst stepping.
package soc_design_fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } fb_state_t;

    localparam int AVM_ADDR_W   = 32;
    localparam int BURSTCOUNT_W = 5;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/soc_design_fb_fifo.sv
// Synchronous show-ahead FIFO: head word is visible whenever the FIFO is not
// empty, and the number of stored words is exported for credit accounting.
module soc_design_fb_fifo
    import soc_design_fb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     i_wr_en,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_rd_en,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_used
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_full;
    logic              w_rd_fire;
    logic              w_wr_fire;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_used    = r_wr_ptr - r_rd_ptr;
    assign o_empty   = (o_used == '0);
    assign w_full    = (o_used == (AW+1)'(DEPTH));
    assign w_rd_fire = i_rd_en && !o_empty;
    assign w_wr_fire = i_wr_en && (!w_full || w_rd_fire);
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/soc_design_fb_reader.sv
// Avalon-MM burst read master that fetches one frame from DDR starting at the
// HPS-programmed base address and streams the words out through a pixel FIFO.
module soc_design_fb_reader
    import soc_design_fb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int BURST_LEN   = 16,
    parameter int FRAME_WORDS = 76800,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [AVM_ADDR_W-1:0]    base_addr,
    input  logic                     frame_start,
    output logic [AVM_ADDR_W-1:0]    avm_address,
    output logic                     avm_read,
    output logic [BURSTCOUNT_W-1:0]  avm_burstcount,
    input  logic                     avm_waitrequest,
    input  logic [DATA_W-1:0]        avm_readdata,
    input  logic                     avm_readdatavalid,
    output logic [DATA_W-1:0]        pix_data,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic                     busy,
    output logic                     overrun,
    output logic                     underflow
);

    localparam int BPW   = bytes_per_word(DATA_W);
    localparam int OUT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int REM_W = $clog2(FRAME_WORDS + 1);

    fb_state_t                r_state;
    fb_state_t                w_state_next;
    logic [AVM_ADDR_W-1:0]    r_addr;
    logic [REM_W-1:0]         r_remaining;
    logic [OUT_W-1:0]         r_outstanding;
    logic                     r_read;
    logic [BURSTCOUNT_W-1:0]  r_burstcount;
    logic                     r_overrun;
    logic                     r_underflow;

    logic                     w_start;
    logic                     w_issue;
    logic                     w_accept;
    logic                     w_beat;
    logic                     w_empty;
    logic [OUT_W-1:0]         w_used;
    logic [BURSTCOUNT_W-1:0]  w_bc;
    logic [OUT_W:0]           w_credit;
    logic                     w_credit_ok;
    logic                     w_last_burst;
    logic                     w_drain_done;
    logic [OUT_W-1:0]         w_out_next;
    logic [AVM_ADDR_W-1:0]    w_addr_inc;

    // Beats with nothing outstanding are stale (e.g. from before a reset) and are dropped.
    assign w_beat = avm_readdatavalid && (r_outstanding != '0);

    assign w_bc = (32'(r_remaining) >= 32'(BURST_LEN)) ? BURSTCOUNT_W'(BURST_LEN)
                                                        : BURSTCOUNT_W'(r_remaining);

    // Space not yet promised to in-flight beats; never negative since used+outstanding <= depth.
    assign w_credit     = (OUT_W+1)'(FIFO_DEPTH) - {1'b0, w_used} - {1'b0, r_outstanding};
    assign w_credit_ok  = (w_credit >= (OUT_W+1)'(w_bc));
    assign w_last_burst = (r_remaining == REM_W'(r_burstcount));
    assign w_drain_done = (r_outstanding == OUT_W'(w_beat));
    assign w_addr_inc   = 32'(r_burstcount) * 32'(BPW);
    assign w_out_next   = r_outstanding
                        + (w_accept ? OUT_W'(r_burstcount) : '0)
                        - (w_beat ? OUT_W'(1) : '0);

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_issue      = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_start) begin
                    w_start      = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_credit_ok) begin
                    w_issue      = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!avm_waitrequest) begin
                    w_accept     = 1'b1;
                    w_state_next = w_last_burst ? ST_DRAIN : ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_outstanding <= '0;
            r_read        <= 1'b0;
            r_burstcount  <= '0;
            r_overrun     <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_out_next;
            if (w_start) begin
                r_addr      <= base_addr & ~AVM_ADDR_W'(BPW - 1);
                r_remaining <= REM_W'(FRAME_WORDS);
            end
            if (w_issue) begin
                r_read       <= 1'b1;
                r_burstcount <= w_bc;
            end
            if (w_accept) begin
                r_read      <= 1'b0;
                r_addr      <= r_addr + w_addr_inc;
                r_remaining <= r_remaining - REM_W'(r_burstcount);
            end
            if (frame_start && (r_state != ST_IDLE)) r_overrun <= 1'b1;
            if (pix_ready && (r_state != ST_IDLE) && w_empty) r_underflow <= 1'b1;
        end
    end

    soc_design_fb_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (reset),
        .i_wr_en   (w_beat),
        .i_wr_data (avm_readdata),
        .i_rd_en   (pix_ready),
        .o_rd_data (pix_data),
        .o_empty   (w_empty),
        .o_used    (w_used)
    );

    assign avm_address    = r_addr;
    assign avm_read       = r_read;
    assign avm_burstcount = r_burstcount;
    assign pix_valid      = !w_empty;
    assign busy           = (r_state != ST_IDLE);
    assign overrun        = r_overrun;
    assign underflow      = r_underflow;

endmodule

// File: tb/tb_soc_design_fb_reader.sv
// Bench for soc_design_fb_reader: Avalon slave model with stall/beat throttling,
// pixel scoreboard, a table of whole-frame vectors and hand-written corner cases.
module tb_soc_design_fb_reader;

    localparam int DATA_W      = 32;
    localparam int BURST_LEN   = 16;
    localparam int FRAME_WORDS = 40;
    localparam int FIFO_DEPTH  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       base_addr;
    logic              frame_start;
    logic [31:0]       avm_address;
    logic              avm_read;
    logic [4:0]        avm_burstcount;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              busy;
    logic              overrun;
    logic              underflow;

    always #5 clk = ~clk;

    soc_design_fb_reader #(
        .DATA_W      (DATA_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .base_addr         (base_addr),
        .frame_start       (frame_start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .pix_data          (pix_data),
        .pix_valid         (pix_valid),
        .pix_ready         (pix_ready),
        .busy              (busy),
        .overrun           (overrun),
        .underflow         (underflow)
    );

    typedef struct {
        logic [31:0]      base;
        int               stall_burst;
        int               stall_cycles;
        logic [2:0][31:0] exp_addr;
        logic [2:0][4:0]  exp_bc;
    } vec_t;

    vec_t        vecs [3];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] beat_q [$];
    logic [31:0] acc_addr_q [$];
    logic [4:0]  acc_bc_q [$];
    int          cyc = 0;
    int          stall_at = -1;
    int          stall_cycles = 0;
    int          stall_left = 0;
    bit          in_burst = 1'b0;
    logic [31:0] ref_addr;
    logic [4:0]  ref_bc;
    int          beat_budget = -1;
    int          beats_given = 0;
    int          last_beat_cyc = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16]};
    endfunction

    function automatic vec_t make_vec(input logic [31:0] base, input int sb, input int sc,
                                      input logic [31:0] a0, input logic [31:0] a1,
                                      input logic [31:0] a2);
        vec_t v;
        v.base         = base;
        v.stall_burst  = sb;
        v.stall_cycles = sc;
        v.exp_addr[0]  = a0;
        v.exp_addr[1]  = a1;
        v.exp_addr[2]  = a2;
        v.exp_bc[0]    = 5'd16;
        v.exp_bc[1]    = 5'd16;
        v.exp_bc[2]    = 5'd8;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decide slave and consumer behaviour for the coming rising edge, then move to the next falling edge.
    task automatic tick();
        logic [31:0] w;
        if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL extra_pixel: got %h, required no word", pix_data);
            end else begin
                w = exp_q.pop_front();
                chk("pixel", pix_data, w);
            end
        end
        avm_readdatavalid = 1'b0;
        if (beat_q.size() > 0 && beat_budget != 0) begin
            avm_readdata      = word_of(beat_q.pop_front());
            avm_readdatavalid = 1'b1;
            beats_given++;
            last_beat_cyc = cyc;
            if (beat_budget > 0) beat_budget--;
        end
        avm_waitrequest = 1'b0;
        if (!avm_read) begin
            in_burst = 1'b0;
        end else begin
            if (!in_burst) begin
                in_burst   = 1'b1;
                ref_addr   = avm_address;
                ref_bc     = avm_burstcount;
                stall_left = (acc_addr_q.size() == stall_at) ? stall_cycles : 0;
            end else begin
                chk("hold_addr", avm_address, ref_addr);
                chk("hold_bc", 32'(avm_burstcount), 32'(ref_bc));
            end
            if (stall_left > 0) begin
                stall_left--;
                avm_waitrequest = 1'b1;
            end else begin
                acc_addr_q.push_back(avm_address);
                acc_bc_q.push_back(avm_burstcount);
                for (int i = 0; i < int'(avm_burstcount); i++)
                    beat_q.push_back(avm_address + 32'(4 * i));
                in_burst = 1'b0;
                $display("burst %0d accepted: addr=%h count=%0d", acc_addr_q.size() - 1,
                         avm_address, avm_burstcount);
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic push_frame(input logic [31:0] a);
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < ((b == 2) ? 8 : 16); i++)
                exp_q.push_back(word_of(a + 32'(64 * b + 4 * i)));
    endtask

    task automatic pulse_start(input logic [31:0] a);
        base_addr   = a;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 2000 && busy; n++) tick();
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200 && pix_valid; n++) tick();
        chk("fifo_drained", 32'(pix_valid), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int start;
        start        = acc_addr_q.size();
        stall_at     = (v.stall_burst < 0) ? -1 : start + v.stall_burst;
        stall_cycles = v.stall_cycles;
        pix_ready    = 1'b1;
        beats_given  = 0;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < int'(v.exp_bc[b]); i++)
                exp_q.push_back(word_of(v.exp_addr[b] + 32'(4 * i)));
        pulse_start(v.base);
        wait_idle("frame_done");
        chk("busy_drop_cycle", 32'(cyc), 32'(last_beat_cyc + 1));
        chk("beats_per_frame", 32'(beats_given), 32'(FRAME_WORDS));
        wait_drain();
        chk("accept_count", 32'(acc_addr_q.size() - start), 32'd3);
        for (int b = 0; b < 3; b++) begin
            if (start + b < acc_addr_q.size()) begin
                chk("burst_addr", acc_addr_q[start + b], v.exp_addr[b]);
                chk("burst_count", 32'(acc_bc_q[start + b]), 32'(v.exp_bc[b]));
            end
        end
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        stall_at = -1;
    endtask

    task automatic chk_reset_state();
        chk("rst_avm_read", 32'(avm_read), 32'd0);
        chk("rst_avm_address", avm_address, 32'd0);
        chk("rst_avm_burstcount", 32'(avm_burstcount), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    endtask

    initial begin
        int start;
        vecs[0] = make_vec(32'h3000_0003, -1, 0, 32'h3000_0000, 32'h3000_0040, 32'h3000_0080);
        vecs[1] = make_vec(32'h3000_0003,  1, 5, 32'h3000_0000, 32'h3000_0040, 32'h3000_0080);
        vecs[2] = make_vec(32'hFFFF_FFC0, -1, 0, 32'hFFFF_FFC0, 32'h0000_0000, 32'h0000_0040);

        reset             = 1'b1;
        base_addr         = '0;
        frame_start       = 1'b0;
        pix_ready         = 1'b0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        chk_reset_state();
        reset = 1'b0;
        tick();

        // Whole-frame vectors: plain fetch, stalled second burst, address wrap.
        for (int v = 0; v < 3; v++) begin
            $display("vector %0d: base=%h", v, vecs[v].base);
            run_vec(vecs[v]);
            if (v == 0) chk("underflow_set", 32'(underflow), 32'd1);
        end
        chk("overrun_clear", 32'(overrun), 32'd0);

        // Back-pressure: FIFO fills, third burst waits for credit.
        $display("backpressure sequence");
        start     = acc_addr_q.size();
        pix_ready = 1'b0;
        push_frame(32'h4000_0000);
        pulse_start(32'h4000_0000);
        for (int n = 0; n < 300; n++) begin
            if (acc_addr_q.size() == start + 2 && beat_q.size() == 0) break;
            tick();
        end
        repeat (20) tick();
        chk("bp_accepts_full", 32'(acc_addr_q.size() - start), 32'd2);
        chk("bp_read_low_full", 32'(avm_read), 32'd0);
        pix_ready = 1'b1;
        repeat (7) tick();
        pix_ready = 1'b0;
        repeat (10) tick();
        chk("bp_accepts_7free", 32'(acc_addr_q.size() - start), 32'd2);
        chk("bp_read_low_7free", 32'(avm_read), 32'd0);
        pix_ready = 1'b1;
        tick();
        pix_ready = 1'b0;
        for (int n = 0; n < 20 && acc_addr_q.size() < start + 3; n++) tick();
        chk("bp_accepts_8free", 32'(acc_addr_q.size() - start), 32'd3);
        pix_ready = 1'b1;
        wait_idle("bp_done");
        wait_drain();
        chk("bp_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // Overrun: second frame_start mid-frame is ignored but flagged.
        $display("overrun sequence");
        start = acc_addr_q.size();
        push_frame(32'h1000_0000);
        pulse_start(32'h1000_0000);
        repeat (5) tick();
        pulse_start(32'h2000_0000);
        chk("overrun_set", 32'(overrun), 32'd1);
        wait_idle("ovr_done");
        wait_drain();
        chk("ovr_accepts", 32'(acc_addr_q.size() - start), 32'd3);
        if (acc_addr_q.size() >= start + 3) begin
            chk("ovr_addr0", acc_addr_q[start], 32'h1000_0000);
            chk("ovr_addr2", acc_addr_q[start + 2], 32'h1000_0080);
        end
        chk("ovr_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        start = acc_addr_q.size();
        push_frame(32'h2000_0000);
        pulse_start(32'h2000_0000);
        chk("new_frame_busy", 32'(busy), 32'd1);
        wait_idle("new_frame_done");
        wait_drain();
        if (acc_addr_q.size() > start) chk("new_frame_addr0", acc_addr_q[start], 32'h2000_0000);
        chk("new_frame_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Reset while the second burst is stalled with 8 beats of the first still outstanding.
        $display("reset-mid-burst sequence");
        start        = acc_addr_q.size();
        pix_ready    = 1'b0;
        beat_budget  = 8;
        beats_given  = 0;
        stall_at     = start + 1;
        stall_cycles = 50;
        push_frame(32'h5000_0000);
        pulse_start(32'h5000_0000);
        for (int n = 0; n < 200; n++) begin
            if (acc_addr_q.size() == start + 1 && beats_given == 8 && avm_waitrequest) break;
            tick();
        end
        repeat (2) tick();
        chk("rst_setup_stalled", 32'(avm_waitrequest), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        chk_reset_state();
        beat_budget = -1;
        stall_at    = -1;
        repeat (12) tick();
        chk("late_beats_dropped", 32'(pix_valid), 32'd0);
        chk("late_beats_idle", 32'(busy), 32'd0);

        $display("post-reset vector");
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
